// File: rtl/ppm_frame_sequencer.sv
// Frame-level controller for the PPM receive path: frames the byte stream between
// SOF/EOF, gates the symbol decoder, and reports clean frames or abort causes.
module ppm_frame_sequencer #(
    parameter int unsigned MAX_BYTES   = 64,
    parameter int unsigned TIMEOUT_SYM = 32,
    parameter int unsigned CNT_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_tick,
    input  logic             sof_rcv,
    input  logic             eof_rcv,
    input  logic             byte_vld,
    input  logic [7:0]       byte_in,
    output logic             dec_en,
    output logic [7:0]       Dout,
    output logic             D_en,
    output logic             F_en,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_len,
    output logic             frame_err,
    output logic [1:0]       err_code
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_SYM + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [1:0] CODE_EMPTY    = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CODE_OVERFLOW = 2'd2;
    localparam logic [1:0] CODE_RESYNC   = 2'd3;

    localparam logic [CNT_W-1:0] BYTE_LIMIT = CNT_W'(MAX_BYTES);
    localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_SYM);

    logic [1:0]       state;
    logic [CNT_W-1:0] byte_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic             byte_full;
    logic [CNT_W-1:0] cnt_after;
    logic [TO_W-1:0]  to_inc;
    logic             to_expire;

    // cnt_after is the count including a byte accepted this cycle, so EOF sees it.
    always_comb begin
        byte_full = (byte_cnt >= BYTE_LIMIT);
        cnt_after = byte_vld ? (byte_cnt + CNT_W'(1)) : byte_cnt;
        to_inc    = (to_cnt == TO_LIMIT) ? to_cnt : (to_cnt + TO_W'(1));
        to_expire = sym_tick && !byte_vld && (to_inc == TO_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            to_cnt     <= '0;
            dec_en     <= 1'b0;
            Dout       <= '0;
            D_en       <= 1'b0;
            F_en       <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_err  <= 1'b0;
            err_code   <= '0;
        end else begin
            D_en       <= 1'b0;
            F_en       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sof_rcv) begin
                        state    <= DATA;
                        dec_en   <= 1'b1;
                        F_en     <= 1'b1;
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (sof_rcv) begin
                        frame_err <= 1'b1;
                        err_code  <= CODE_RESYNC;
                        F_en      <= 1'b1;
                        byte_cnt  <= '0;
                        to_cnt    <= '0;
                    end else if (byte_vld && byte_full) begin
                        state     <= ERR;
                        dec_en    <= 1'b0;
                        frame_err <= 1'b1;
                        err_code  <= CODE_OVERFLOW;
                    end else begin
                        if (byte_vld) begin
                            Dout     <= byte_in;
                            D_en     <= 1'b1;
                            byte_cnt <= cnt_after;
                            to_cnt   <= '0;
                        end else if (sym_tick) begin
                            to_cnt <= to_inc;
                        end
                        if (eof_rcv) begin
                            dec_en <= 1'b0;
                            if (cnt_after == '0) begin
                                state     <= ERR;
                                frame_err <= 1'b1;
                                err_code  <= CODE_EMPTY;
                            end else begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                                frame_len  <= cnt_after;
                            end
                        end else if (to_expire) begin
                            state     <= ERR;
                            dec_en    <= 1'b0;
                            frame_err <= 1'b1;
                            err_code  <= CODE_TIMEOUT;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    dec_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppm_frame_sequencer.sv
// Directed bench for ppm_frame_sequencer with hand-computed expectations.
module tb_ppm_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sym_tick, sof_rcv, eof_rcv, byte_vld;
    logic [7:0] byte_in;
    logic       dec_en, D_en, F_en, frame_done, frame_err;
    logic [7:0] Dout;
    logic [6:0] frame_len;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_fail   = 0;
    int den_cnt;

    ppm_frame_sequencer #(
        .MAX_BYTES  (64),
        .TIMEOUT_SYM(32),
        .CNT_W      (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_tick  (sym_tick),
        .sof_rcv   (sof_rcv),
        .eof_rcv   (eof_rcv),
        .byte_vld  (byte_vld),
        .byte_in   (byte_in),
        .dec_en    (dec_en),
        .Dout      (Dout),
        .D_en      (D_en),
        .F_en      (F_en),
        .frame_done(frame_done),
        .frame_len (frame_len),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        sym_tick = 1'b0; sof_rcv = 1'b0; eof_rcv = 1'b0; byte_vld = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_vld = 1'b1; byte_in = b;
        cyc();
        byte_vld = 1'b0;
    endtask

    task automatic start_frame();
        sof_rcv = 1'b1;
        cyc();
        sof_rcv = 1'b0;
    endtask

    task automatic tick();
        sym_tick = 1'b1;
        cyc();
        sym_tick = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; byte_in = 8'h00; clr();
        cyc(); cyc();
        chk("rst_dec_en", dec_en, 0);
        chk("rst_outs", {Dout, D_en, F_en, frame_done, frame_err, err_code}, 0);
        chk("rst_len", frame_len, 0);
        rst = 1'b0;
        cyc();

        // Idle ignores eof and bytes
        eof_rcv = 1'b1; byte_vld = 1'b1; byte_in = 8'h99;
        cyc(); clr();
        chk("idle_ignore", {D_en, frame_done, frame_err, dec_en}, 0);

        // Test 1: clean two-byte frame
        start_frame();
        chk("t1_fen", F_en, 1);
        chk("t1_dec_en", dec_en, 1);
        cyc();
        chk("t1_fen_once", F_en, 0);
        send_byte(8'hA5);
        chk("t1_den_a", {D_en, Dout}, {1'b1, 8'hA5});
        cyc();
        chk("t1_den_low", D_en, 0);
        send_byte(8'h3C);
        chk("t1_den_b", {D_en, Dout}, {1'b1, 8'h3C});
        eof_rcv = 1'b1; cyc(); clr();
        chk("t1_done", {frame_done, frame_err, dec_en}, 3'b100);
        chk("t1_len", frame_len, 2);
        cyc();
        chk("t1_done_pulse", frame_done, 0);

        // Test 2: empty frame
        start_frame();
        eof_rcv = 1'b1; cyc(); clr();
        chk("t2_err", {frame_err, err_code, frame_done}, {1'b1, 2'd0, 1'b0});
        cyc();
        chk("t2_err_pulse", {frame_err, frame_done}, 0);
        chk("t2_len_held", frame_len, 2);

        // Test 3a: 32 idle ticks time out
        start_frame();
        for (int i = 0; i < 31; i++) tick();
        chk("t3_no_to_31", {frame_err, dec_en}, 2'b01);
        sym_tick = 1'b1; cyc(); clr();
        chk("t3_timeout", {frame_err, err_code, dec_en}, {1'b1, 2'd1, 1'b0});
        cyc();

        // Test 3b: byte on the expiring tick wins and restarts the timer
        start_frame();
        for (int i = 0; i < 31; i++) tick();
        sym_tick = 1'b1; byte_vld = 1'b1; byte_in = 8'h11;
        cyc(); clr();
        chk("t3b_byte_wins", {frame_err, D_en, dec_en}, 3'b011);
        for (int i = 0; i < 31; i++) tick();
        chk("t3b_no_to", {frame_err, dec_en}, 2'b01);
        send_byte(8'h22);
        eof_rcv = 1'b1; cyc(); clr();
        chk("t3b_done", {frame_done, frame_len}, {1'b1, 7'd2});
        cyc();

        // Test 4: overflow on 65th byte
        start_frame();
        den_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            byte_vld = 1'b1; byte_in = 8'(i);
            cyc();
            if (D_en) den_cnt++;
        end
        byte_vld = 1'b0;
        chk("t4_den_count", den_cnt, 64);
        chk("t4_last_byte", Dout, 8'h3F);
        chk("t4_no_err_yet", {frame_err, dec_en}, 2'b01);
        send_byte(8'hEE);
        chk("t4_overflow", {D_en, frame_err, err_code, dec_en}, {1'b0, 1'b1, 2'd2, 1'b0});
        chk("t4_dout_kept", Dout, 8'h3F);
        cyc();

        // Test 5: resync mid-frame; byte in the sof cycle is dropped
        start_frame();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        sof_rcv = 1'b1; byte_vld = 1'b1; byte_in = 8'h44;
        cyc(); clr();
        chk("t5_resync", {frame_err, err_code, F_en, D_en, dec_en}, {1'b1, 2'd3, 1'b1, 1'b0, 1'b1});
        cyc();
        chk("t5_pulses", {frame_err, F_en}, 0);
        send_byte(8'h77);
        eof_rcv = 1'b1; cyc(); clr();
        chk("t5_len", {frame_done, frame_len}, {1'b1, 7'd1});
        chk("t5_code_held", err_code, 3);
        cyc();

        // Test 6: byte and eof in the same cycle
        start_frame();
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
        byte_vld = 1'b1; eof_rcv = 1'b1; byte_in = 8'h5A;
        cyc(); clr();
        chk("t6_den", {D_en, Dout}, {1'b1, 8'h5A});
        chk("t6_done", {frame_done, frame_len}, {1'b1, 7'd5});
        cyc();

        // Reset mid-frame
        start_frame();
        send_byte(8'hC3);
        rst = 1'b1;
        cyc();
        chk("rst_mid_outs", {dec_en, Dout, D_en, F_en, frame_done, frame_err, err_code}, 0);
        chk("rst_mid_len", frame_len, 0);
        rst = 1'b0;
        send_byte(8'hAB);
        chk("rst_mid_idle", {D_en, dec_en}, 0);
        start_frame();
        chk("rst_mid_restart", {F_en, dec_en}, 2'b11);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
